// File: rtl/snake_body_engine_if.sv
// Bus between the snake body engine and its neighbours: direction requests in,
// packed segment coordinates, length, fruit position and status out.
interface snake_body_engine_if;
  logic          up;
  logic          down;
  logic          left;
  logic          right;
  logic [2999:0] out_x;
  logic [2999:0] out_y;
  logic [6:0]    snake_length;
  logic [9:0]    fruit_x;
  logic [9:0]    fruit_y;
  logic          game_over;
  logic          move_tick;

  // Driver of direction requests, consumer of game state.
  modport master (
    output up, down, left, right,
    input  out_x, out_y, snake_length, fruit_x, fruit_y, game_over, move_tick
  );

  // The engine itself.
  modport slave (
    input  up, down, left, right,
    output out_x, out_y, snake_length, fruit_x, fruit_y, game_over, move_tick
  );
endinterface

// File: rtl/snake_body_engine.sv
// Snake body engine: segment shift register advanced one grid step per game
// tick, fruit eating with LFSR relocation, wall and self collision detection.
// Optional macro WRAP_EN: wall crossings wrap around instead of killing.
module snake_body_engine #(
  parameter int unsigned TICK_DIV  = 2500000,
  parameter int unsigned MAX_LEN   = 100,
  parameter int unsigned START_LEN = 3,
  parameter int unsigned X_ORG     = 149,
  parameter int unsigned Y_ORG     = 40,
  parameter int unsigned START_COL = 25,
  parameter int unsigned START_ROW = 26
) (
  input logic                 clk,
  input logic                 rst,
  snake_body_engine_if.slave  bus
);

  localparam int unsigned    CW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_TOP = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  CNT_PRE = CW'(TICK_DIV - 2);
  localparam logic [9:0]     X_MIN   = 10'(X_ORG);
  localparam logic [9:0]     X_MAX   = 10'(X_ORG + 630);
  localparam logic [9:0]     Y_MIN   = 10'(Y_ORG);
  localparam logic [9:0]     Y_MAX   = 10'(Y_ORG + 470);
  localparam logic [6:0]     LEN_MAX = 7'(MAX_LEN);
  localparam logic [6:0]     LEN_RST = 7'(START_LEN);

  typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;
  typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_e;

  state_e         state_q;
  dir_e           dir_q;
  dir_e           pend_dir_q;
  logic [CW-1:0]  cnt_q;
  logic           move_tick_q;
  logic           game_over_q;
  logic [15:0]    lfsr_q;
  logic [6:0]     len_q;
  logic [9:0]     fruit_x_q;
  logic [9:0]     fruit_y_q;
  logic [9:0]     seg_x_q [MAX_LEN];
  logic [9:0]     seg_y_q [MAX_LEN];

  logic           req_valid;
  dir_e           req_dir;
  dir_e           ref_dir;
  logic           accept;
  logic [9:0]     nh_x;
  logic [9:0]     nh_y;
  logic           at_edge;
  logic           eat;
  logic           self_hit;
  logic           kill;
  logic [15:0]    lfsr_next;
  logic [5:0]     fr_col;
  logic [5:0]     fr_row;
  logic [9:0]     fr_x;
  logic [9:0]     fr_y;

  function automatic logic is_opposite(dir_e a, dir_e b);
    return ((a == DirUp)   && (b == DirDown))  || ((a == DirDown)  && (b == DirUp)) ||
           ((a == DirLeft) && (b == DirRight)) || ((a == DirRight) && (b == DirLeft));
  endfunction

  // Prioritised direction request, filtered against the direction being executed.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = DirRight;
    if (bus.up)         req_dir = DirUp;
    else if (bus.down)  req_dir = DirDown;
    else if (bus.left)  req_dir = DirLeft;
    else if (bus.right) req_dir = DirRight;
    else                req_valid = 1'b0;
    // On a move cycle pend_dir is what executes, so reversal is judged against it.
    ref_dir = move_tick_q ? pend_dir_q : dir_q;
    accept  = req_valid && !is_opposite(req_dir, ref_dir);
  end

  // Next head position; at_edge marks a step off the grid, which wraps.
  always_comb begin
    nh_x    = seg_x_q[0];
    nh_y    = seg_y_q[0];
    at_edge = 1'b0;
    unique case (pend_dir_q)
      DirUp: begin
        at_edge = (seg_y_q[0] == Y_MIN);
        nh_y    = at_edge ? Y_MAX : seg_y_q[0] - 10'd10;
      end
      DirDown: begin
        at_edge = (seg_y_q[0] == Y_MAX);
        nh_y    = at_edge ? Y_MIN : seg_y_q[0] + 10'd10;
      end
      DirLeft: begin
        at_edge = (seg_x_q[0] == X_MIN);
        nh_x    = at_edge ? X_MAX : seg_x_q[0] - 10'd10;
      end
      DirRight: begin
        at_edge = (seg_x_q[0] == X_MAX);
        nh_x    = at_edge ? X_MIN : seg_x_q[0] + 10'd10;
      end
    endcase
  end

  // Eat and collision detection; the tail only counts when growth keeps it.
  always_comb begin
    eat      = (nh_x == fruit_x_q) && (nh_y == fruit_y_q);
    self_hit = 1'b0;
    for (int k = 1; k < int'(MAX_LEN); k++) begin
      if ((k + 1 < int'(len_q)) || (eat && (k + 1 == int'(len_q)))) begin
        if ((seg_x_q[k] == nh_x) && (seg_y_q[k] == nh_y)) self_hit = 1'b1;
      end
    end
`ifdef WRAP_EN
    kill = self_hit;
`else
    kill = at_edge | self_hit;
`endif
  end

  // LFSR step and fruit relocation target.
  always_comb begin
    lfsr_next = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    fr_col    = lfsr_q[5:0];
    fr_row    = (lfsr_q[13:8] >= 6'd48) ? lfsr_q[13:8] - 6'd16 : lfsr_q[13:8];
    fr_x      = X_MIN + ({4'd0, fr_col} * 10'd10);
    fr_y      = Y_MIN + ({4'd0, fr_row} * 10'd10);
  end

  // Game FSM, tick divider, body shift register and fruit state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      dir_q       <= DirRight;
      pend_dir_q  <= DirRight;
      cnt_q       <= '0;
      move_tick_q <= 1'b0;
      game_over_q <= 1'b0;
      lfsr_q      <= 16'hACE1;
      len_q       <= LEN_RST;
      fruit_x_q   <= 10'd549;
      fruit_y_q   <= 10'd140;
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        seg_x_q[i] <= (i < int'(START_LEN)) ? 10'(int'(X_ORG) + 10 * (int'(START_COL) - i))
                                            : 10'd0;
        seg_y_q[i] <= (i < int'(START_LEN)) ? 10'(Y_ORG + 10 * START_ROW) : 10'd0;
      end
    end else begin
      lfsr_q      <= lfsr_next;
      move_tick_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (accept) begin
            pend_dir_q <= req_dir;
            state_q    <= StRun;
          end
        end
        StRun: begin
          cnt_q       <= (cnt_q == CNT_TOP) ? '0 : cnt_q + 1'b1;
          // Pulse lands on the cycle the counter sits at its top value.
          move_tick_q <= (cnt_q == CNT_PRE);
          if (accept) pend_dir_q <= req_dir;
          if (move_tick_q) begin
            dir_q <= pend_dir_q;
            if (kill) begin
              state_q     <= StDead;
              game_over_q <= 1'b1;
              cnt_q       <= '0;
            end else begin
              for (int i = int'(MAX_LEN) - 1; i > 0; i--) begin
                seg_x_q[i] <= seg_x_q[i-1];
                seg_y_q[i] <= seg_y_q[i-1];
              end
              seg_x_q[0] <= nh_x;
              seg_y_q[0] <= nh_y;
              if (eat) begin
                if (len_q < LEN_MAX) len_q <= len_q + 7'd1;
                fruit_x_q <= fr_x;
                fruit_y_q <= fr_y;
              end
            end
          end
        end
        StDead: begin
          cnt_q <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Pack segment registers onto the renderer buses; unused slots read zero.
  always_comb begin
    bus.out_x = '0;
    bus.out_y = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      bus.out_x[i*10 +: 10] = seg_x_q[i];
      bus.out_y[i*10 +: 10] = seg_y_q[i];
    end
  end

  assign bus.snake_length = len_q;
  assign bus.fruit_x      = fruit_x_q;
  assign bus.fruit_y      = fruit_y_q;
  assign bus.game_over    = game_over_q;
  assign bus.move_tick    = move_tick_q;

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: reset state, idle hold, moves, reversal
// rejection, eating with fruit relocation, wall and self collision, async reset.
module tb_snake_body_engine;

  localparam int DirU = 0;
  localparam int DirD = 1;
  localparam int DirL = 2;
  localparam int DirR = 3;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  snake_body_engine_if bus  ();
  snake_body_engine_if bus5 ();

  snake_body_engine #(
    .TICK_DIV (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  snake_body_engine #(
    .TICK_DIV  (4),
    .START_LEN (5)
  ) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR; last_lfsr holds the value seen during the latest move cycle.
  logic [15:0] m_lfsr;
  logic [15:0] last_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr    <= 16'hACE1;
      last_lfsr <= 16'h0;
    end else begin
      m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      if (bus.move_tick) last_lfsr <= m_lfsr;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input int d, input logic v);
    if (sel) begin
      case (d)
        DirU: bus5.up = v;
        DirD: bus5.down = v;
        DirL: bus5.left = v;
        default: bus5.right = v;
      endcase
    end else begin
      case (d)
        DirU: bus.up = v;
        DirD: bus.down = v;
        DirL: bus.left = v;
        default: bus.right = v;
      endcase
    end
  endtask

  task automatic press(input bit sel, input int d);
    drive(sel, d, 1'b1);
    tick();
    drive(sel, d, 1'b0);
  endtask

  // Wait (bounded) for a move_tick cycle, then step past the edge that applies it.
  task automatic wait_move(input bit sel);
    int n;
    n = 0;
    while (((sel ? bus5.move_tick : bus.move_tick) !== 1'b1) && (n < 20)) begin
      tick();
      n++;
    end
    tests++;
    assert (n < 20) else begin
      failed++;
      $error("FAIL move_timeout: observed %0d cycles expected < 20", n);
    end
    tick();
  endtask

  task automatic count_ticks(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.move_tick === 1'b1) pulses++;
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [9:0] exp_fx;
  logic [9:0] exp_fy;
  logic [5:0] rrow;
  int         pulses;

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    bus.up = 1'b0; bus.down = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
    bus5.up = 1'b0; bus5.down = 1'b0; bus5.left = 1'b0; bus5.right = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_head_x", 32'(bus.out_x[9:0]), 399);
    check("rst_head_y", 32'(bus.out_y[9:0]), 300);
    check("rst_seg1_x", 32'(bus.out_x[19:10]), 389);
    check("rst_seg2_x", 32'(bus.out_x[29:20]), 379);
    check("rst_seg2_y", 32'(bus.out_y[29:20]), 300);
    check("rst_seg3_x", 32'(bus.out_x[39:30]), 0);
    check("rst_seg99_y", 32'(bus.out_y[999:990]), 0);
    check("rst_len", 32'(bus.snake_length), 3);
    check("rst_fruit_x", 32'(bus.fruit_x), 549);
    check("rst_fruit_y", 32'(bus.fruit_y), 140);
    check("rst_game_over", 32'(bus.game_over), 0);
    check("rst_move_tick", 32'(bus.move_tick), 0);
    check("rst5_seg4_x", 32'(bus5.out_x[49:40]), 359);
    check("rst5_len", 32'(bus5.snake_length), 5);

    // Idle without presses: nothing moves
    rst = 1'b0;
    count_ticks(20, pulses);
    check("idle_no_tick", 32'(pulses), 0);
    check("idle_head_x", 32'(bus.out_x[9:0]), 399);
    check("idle_len", 32'(bus.snake_length), 3);

    // First move right, then a rejected reversal
    press(1'b0, DirR);
    wait_move(1'b0);
    check("mv1_head_x", 32'(bus.out_x[9:0]), 409);
    check("mv1_seg1_x", 32'(bus.out_x[19:10]), 399);
    check("mv1_seg2_x", 32'(bus.out_x[29:20]), 389);
    check("mv1_head_y", 32'(bus.out_y[9:0]), 300);
    press(1'b0, DirL);
    wait_move(1'b0);
    check("rev_head_x", 32'(bus.out_x[9:0]), 419);
    check("rev_head_y", 32'(bus.out_y[9:0]), 300);

    // Eat the initial fruit at column 40, row 10
    do_reset();
    press(1'b0, DirR);
    repeat (15) wait_move(1'b0);
    check("r15_head_x", 32'(bus.out_x[9:0]), 549);
    check("r15_head_y", 32'(bus.out_y[9:0]), 300);
    press(1'b0, DirU);
    repeat (15) wait_move(1'b0);
    check("u15_head_y", 32'(bus.out_y[9:0]), 150);
    check("u15_len", 32'(bus.snake_length), 3);
    wait_move(1'b0);
    check("eat_head_x", 32'(bus.out_x[9:0]), 549);
    check("eat_head_y", 32'(bus.out_y[9:0]), 140);
    check("eat_len", 32'(bus.snake_length), 4);
    check("eat_seg1_y", 32'(bus.out_y[19:10]), 150);
    check("eat_tail_x", 32'(bus.out_x[39:30]), 549);
    check("eat_tail_y", 32'(bus.out_y[39:30]), 170);
    rrow   = last_lfsr[13:8];
    if (rrow >= 6'd48) rrow = rrow - 6'd16;
    exp_fx = 10'd149 + 10'd10 * {4'd0, last_lfsr[5:0]};
    exp_fy = 10'd40 + 10'd10 * {4'd0, rrow};
    check("eat_fruit_x", 32'(bus.fruit_x), 32'(exp_fx));
    check("eat_fruit_y", 32'(bus.fruit_y), 32'(exp_fy));
    check("eat_game_over", 32'(bus.game_over), 0);

    // Right wall
    do_reset();
    press(1'b0, DirR);
    repeat (38) wait_move(1'b0);
    check("w38_head_x", 32'(bus.out_x[9:0]), 779);
    check("w38_game_over", 32'(bus.game_over), 0);
    wait_move(1'b0);
`ifdef WRAP_EN
    check("wrap_head_x", 32'(bus.out_x[9:0]), 149);
    check("wrap_seg1_x", 32'(bus.out_x[19:10]), 779);
    check("wrap_game_over", 32'(bus.game_over), 0);
`else
    check("wall_game_over", 32'(bus.game_over), 1);
    check("wall_head_x", 32'(bus.out_x[9:0]), 779);
    check("wall_seg1_x", 32'(bus.out_x[19:10]), 769);
    count_ticks(12, pulses);
    check("wall_no_tick", 32'(pulses), 0);
    press(1'b0, DirU);
    count_ticks(12, pulses);
    check("dead_press_no_tick", 32'(pulses), 0);
    check("dead_head_y", 32'(bus.out_y[9:0]), 300);
`endif

    // Self collision on a length-5 snake: up, left, down into segment 3
    do_reset();
    press(1'b1, DirU);
    wait_move(1'b1);
    check("s_up_head_x", 32'(bus5.out_x[9:0]), 399);
    check("s_up_head_y", 32'(bus5.out_y[9:0]), 290);
    press(1'b1, DirL);
    wait_move(1'b1);
    check("s_left_head_x", 32'(bus5.out_x[9:0]), 389);
    check("s_left_game_over", 32'(bus5.game_over), 0);
    press(1'b1, DirD);
    wait_move(1'b1);
    check("self_game_over", 32'(bus5.game_over), 1);
    check("self_head_x", 32'(bus5.out_x[9:0]), 389);
    check("self_head_y", 32'(bus5.out_y[9:0]), 290);
    check("self_seg3_y", 32'(bus5.out_y[39:30]), 300);
    check("self_seg4_x", 32'(bus5.out_x[49:40]), 379);
    check("self_len", 32'(bus5.snake_length), 5);

    // Asynchronous reset between clock edges
    do_reset();
    press(1'b0, DirR);
    wait_move(1'b0);
    check("pre_arst_head_x", 32'(bus.out_x[9:0]), 409);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_head_x", 32'(bus.out_x[9:0]), 399);
    check("arst_seg2_x", 32'(bus.out_x[29:20]), 379);
    check("arst_move_tick", 32'(bus.move_tick), 0);
    check("arst_len", 32'(bus.snake_length), 3);
    #1;
    rst = 1'b0;
    tick();
    count_ticks(12, pulses);
    check("arst_idle_no_tick", 32'(pulses), 0);
    check("arst_idle_head_x", 32'(bus.out_x[9:0]), 399);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
